// File: rtl/ipv6_depacketiser_if.sv
// Byte-stream bundle between the radio receiver, the depacketiser and the payload consumer.
// The slave modport is the depacketiser's view; master is the surrounding environment.
interface ipv6_depacketiser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_ready;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_last;
    logic       pay_ready;
    logic [7:0] hdr_next;
    logic [7:0] hdr_src;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    modport slave (
        input  rx_data, rx_valid, rx_sop, pay_ready,
        output rx_ready, pay_data, pay_valid, pay_last, hdr_next, hdr_src,
               pkt_done, pkt_err, err_code
    );

    modport master (
        output rx_data, rx_valid, rx_sop, pay_ready,
        input  rx_ready, pay_data, pay_valid, pay_last, hdr_next, hdr_src,
               pkt_done, pkt_err, err_code
    );
endinterface

// File: rtl/ipv6_depacketiser.sv
// Receive-side IPv6 depacketiser: checks the 40-byte fixed header, filters on destination
// and streams payload of accepted packets through a one-deep output register.
module ipv6_depacketiser #(
    parameter logic [7:0]  NODE_ADDR   = 8'h01,
    parameter int unsigned MAX_PAYLOAD = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                clk,
    input logic                rst,
    ipv6_depacketiser_if.slave bus
);
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [15:0] MaxLen      = 16'(MAX_PAYLOAD);
    localparam logic [1:0]  ErrVersion  = 2'd0;
    localparam logic [1:0]  ErrLength   = 2'd1;
    localparam logic [1:0]  ErrAbort    = 2'd2;
    localparam logic [1:0]  ErrAddr     = 2'd3;

    typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrop} state_e;

    state_e      r_state, w_state;
    logic [5:0]  r_cnt, w_cnt;
    logic [7:0]  r_len_hi, w_len_hi;
    logic [15:0] r_rem, w_rem;
    logic [7:0]  r_idle, w_idle;
    logic [7:0]  r_next_tmp, w_next_tmp;
    logic [7:0]  r_src_tmp, w_src_tmp;
    logic [7:0]  r_hdr_next, w_hdr_next;
    logic [7:0]  r_hdr_src, w_hdr_src;
    logic [7:0]  r_pay_data, w_pay_data;
    logic        r_pay_valid, w_pay_valid;
    logic        r_pay_last, w_pay_last;
    logic        r_pkt_done, w_pkt_done;
    logic        r_pkt_err, w_pkt_err;
    logic [1:0]  r_err_code, w_err_code;

    logic        w_rx_ready;
    logic        w_accept;
    logic        w_ver_ok;
    logic        w_addr_ok;
    logic        w_timeout;
    logic [15:0] w_len;
    logic        w_len_bad;

    // In PAY the output register is the only buffer, so intake stalls while it is full.
    assign w_rx_ready = !rst && ((r_state != StPay) || !r_pay_valid || bus.pay_ready);
    assign w_accept   = bus.rx_valid && w_rx_ready;
    assign w_ver_ok   = (bus.rx_data[7:4] == 4'h6);
    assign w_addr_ok  = (bus.rx_data == NODE_ADDR) || (bus.rx_data == 8'hFF);
    assign w_len      = {r_len_hi, bus.rx_data};
    assign w_len_bad  = (w_len == 16'd0) || (w_len > MaxLen);
    assign w_timeout  = (r_state != StIdle) && !bus.rx_valid && (r_idle == TimeoutLast);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_len_hi    = r_len_hi;
        w_rem       = r_rem;
        w_idle      = r_idle;
        w_next_tmp  = r_next_tmp;
        w_src_tmp   = r_src_tmp;
        w_hdr_next  = r_hdr_next;
        w_hdr_src   = r_hdr_src;
        w_pay_data  = r_pay_data;
        w_pay_valid = r_pay_valid;
        w_pay_last  = r_pay_last;
        w_pkt_done  = 1'b0;
        w_pkt_err   = 1'b0;
        w_err_code  = r_err_code;

        if (r_pay_valid && bus.pay_ready) begin
            w_pay_valid = 1'b0;
            w_pay_last  = 1'b0;
        end
        if ((r_state != StIdle) && !bus.rx_valid) begin
            w_idle = r_idle + 8'd1;
        end

        if (w_accept) begin
            w_idle = 8'd0;
            if (bus.rx_sop) begin
                // A sop always restarts parsing; an interrupted packet outranks a bad version.
                if ((r_state == StHdr) || (r_state == StPay)) begin
                    w_pkt_err  = 1'b1;
                    w_err_code = ErrAbort;
                end else if (!w_ver_ok) begin
                    w_pkt_err  = 1'b1;
                    w_err_code = ErrVersion;
                end
                w_state = w_ver_ok ? StHdr : StDrop;
                w_cnt   = 6'd1;
            end else begin
                case (r_state)
                    StHdr: begin
                        w_cnt = r_cnt + 6'd1;
                        case (r_cnt)
                            6'd4:  w_len_hi = bus.rx_data;
                            6'd5: begin
                                if (w_len_bad) begin
                                    w_pkt_err  = 1'b1;
                                    w_err_code = ErrLength;
                                    w_state    = StDrop;
                                end else begin
                                    w_rem = w_len;
                                end
                            end
                            6'd6:  w_next_tmp = bus.rx_data;
                            6'd23: w_src_tmp  = bus.rx_data;
                            6'd39: begin
                                if (w_addr_ok) begin
                                    w_hdr_next = r_next_tmp;
                                    w_hdr_src  = r_src_tmp;
                                    w_state    = StPay;
                                end else begin
                                    w_pkt_err  = 1'b1;
                                    w_err_code = ErrAddr;
                                    w_state    = StDrop;
                                end
                            end
                            default: ;
                        endcase
                    end
                    StPay: begin
                        w_pay_data  = bus.rx_data;
                        w_pay_valid = 1'b1;
                        w_pay_last  = (r_rem == 16'd1);
                        w_rem       = r_rem - 16'd1;
                        if (r_rem == 16'd1) begin
                            w_pkt_done = 1'b1;
                            w_state    = StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (w_timeout) begin
            w_idle  = 8'd0;
            w_state = StIdle;
            if (r_state != StDrop) begin
                w_pkt_err  = 1'b1;
                w_err_code = ErrAbort;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 6'd0;
            r_len_hi    <= 8'd0;
            r_rem       <= 16'd0;
            r_idle      <= 8'd0;
            r_next_tmp  <= 8'd0;
            r_src_tmp   <= 8'd0;
            r_hdr_next  <= 8'd0;
            r_hdr_src   <= 8'd0;
            r_pay_data  <= 8'd0;
            r_pay_valid <= 1'b0;
            r_pay_last  <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_len_hi    <= w_len_hi;
            r_rem       <= w_rem;
            r_idle      <= w_idle;
            r_next_tmp  <= w_next_tmp;
            r_src_tmp   <= w_src_tmp;
            r_hdr_next  <= w_hdr_next;
            r_hdr_src   <= w_hdr_src;
            r_pay_data  <= w_pay_data;
            r_pay_valid <= w_pay_valid;
            r_pay_last  <= w_pay_last;
            r_pkt_done  <= w_pkt_done;
            r_pkt_err   <= w_pkt_err;
            r_err_code  <= w_err_code;
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.pay_data  = r_pay_data;
    assign bus.pay_valid = r_pay_valid;
    assign bus.pay_last  = r_pay_last;
    assign bus.hdr_next  = r_hdr_next;
    assign bus.hdr_src   = r_hdr_src;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.pkt_err   = r_pkt_err;
    assign bus.err_code  = r_err_code;
endmodule

// File: tb/tb_ipv6_depacketiser.sv
// Bench for ipv6_depacketiser: packet-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized packet traffic.
module tb_ipv6_depacketiser;
    localparam logic [7:0] NodeAddr = 8'h01;
    localparam int         MaxPay   = 16;
    localparam int         Tmo      = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ipv6_depacketiser_if bus ();

    ipv6_depacketiser #(
        .NODE_ADDR   (NodeAddr),
        .MAX_PAYLOAD (MaxPay),
        .TIMEOUT     (Tmo)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: where we are in the current packet plus the expected outputs.
    bit         m_hdr, m_pay, m_drop;
    int         m_idx, m_rem, m_gap;
    logic [7:0] m_bytes [40];
    logic [7:0] e_data, e_next, e_src;
    bit         e_valid, e_last, e_done, e_err;
    logic [1:0] e_code;

    logic [8:0] obs_pay [$];
    int         obs_err [$];
    int         obs_done, obs_valid;
    logic [7:0] pkt [$];
    int         pr_force = 1;
    bit         gaps = 1'b0;
    bit         last_ready;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hdr = 0; m_pay = 0; m_drop = 0; m_idx = 0; m_rem = 0; m_gap = 0;
        e_data = 8'h00; e_next = 8'h00; e_src = 8'h00;
        e_valid = 0; e_last = 0; e_done = 0; e_err = 0; e_code = 2'd0;
    endfunction

    function automatic void flag_err(input logic [1:0] c);
        e_err  = 1;
        e_code = c;
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic [7:0] d,
                                       input bit pr, input bit acc);
        int len;
        e_done = 0;
        e_err  = 0;
        if (e_valid && pr) begin
            e_valid = 0;
            e_last  = 0;
        end
        if (acc) begin
            m_gap = 0;
            if (s) begin
                if (m_hdr || m_pay) flag_err(2'd2);
                else if (d[7:4] != 4'h6) flag_err(2'd0);
                m_pay = 0;
                m_hdr = (d[7:4] == 4'h6);
                m_drop = !m_hdr;
                m_idx = 1;
                m_bytes[0] = d;
            end else if (m_hdr) begin
                m_bytes[m_idx] = d;
                m_idx++;
                if (m_idx == 6) begin
                    len = {m_bytes[4], m_bytes[5]};
                    if (len == 0 || len > MaxPay) begin
                        flag_err(2'd1);
                        m_hdr = 0;
                        m_drop = 1;
                    end else begin
                        m_rem = len;
                    end
                end else if (m_idx == 40) begin
                    m_hdr = 0;
                    if (d == NodeAddr || d == 8'hFF) begin
                        e_next = m_bytes[6];
                        e_src  = m_bytes[23];
                        m_pay  = 1;
                    end else begin
                        flag_err(2'd3);
                        m_drop = 1;
                    end
                end
            end else if (m_pay) begin
                e_data  = d;
                e_valid = 1;
                m_rem--;
                e_last  = (m_rem == 0);
                if (m_rem == 0) begin
                    e_done = 1;
                    m_pay  = 0;
                end
            end
        end else if (!v && (m_hdr || m_pay || m_drop)) begin
            m_gap++;
            if (m_gap == Tmo) begin
                if (!m_drop) flag_err(2'd2);
                m_hdr = 0; m_pay = 0; m_drop = 0; m_gap = 0;
            end
        end
    endfunction

    task automatic compare_all();
        chk("pay_valid", bus.pay_valid, e_valid);
        chk("pay_last", bus.pay_last, e_last);
        chk("pay_data", bus.pay_data, e_data);
        chk("pkt_done", bus.pkt_done, e_done);
        chk("pkt_err", bus.pkt_err, e_err);
        chk("err_code", bus.err_code, e_code);
        chk("hdr_next", bus.hdr_next, e_next);
        chk("hdr_src", bus.hdr_src, e_src);
        if (bus.pkt_err) obs_err.push_back(int'(bus.err_code));
        if (bus.pkt_done) obs_done++;
        if (bus.pay_valid) obs_valid++;
    endtask

    function automatic bit pick_pr();
        if (pr_force >= 0) return pr_force[0];
        return $urandom_range(0, 9) < 7;
    endfunction

    // One clock: drive just after negedge, predict, then compare on the following negedge.
    task automatic cycle(input bit v, input bit s, input logic [7:0] d, input bit pr,
                         output bit acc);
        bit e_rdy;
        bus.rx_valid  = v;
        bus.rx_sop    = s;
        bus.rx_data   = d;
        bus.pay_ready = pr;
        #1;
        e_rdy = m_pay ? (!e_valid || pr) : 1'b1;
        chk("rx_ready", bus.rx_ready, e_rdy);
        last_ready = bus.rx_ready;
        if (bus.pay_valid && pr) obs_pay.push_back({bus.pay_last, bus.pay_data});
        acc = v && e_rdy;
        @(posedge clk);
        model_step(v, s, d, pr, acc);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), pick_pr(), acc);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s);
        bit acc;
        int tries = 0;
        do begin
            cycle(1'b1, s, d, pick_pr(), acc);
            tries++;
        end while (!acc && tries < 100);
        if (!acc) chk("rx_accept_bound", 0, 1);
    endtask

    task automatic send_pkt(input int upto);
        for (int i = 0; i < upto; i++) begin
            if (gaps && $urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            send_byte(pkt[i], i == 0);
        end
    endtask

    task automatic build(input int len, input logic [7:0] dst, input logic [7:0] nxt,
                         input logic [7:0] src, input int npay);
        pkt.delete();
        for (int i = 0; i < 40 + npay; i++) pkt.push_back(8'($urandom));
        pkt[0]  = {4'h6, 4'($urandom)};
        pkt[4]  = 8'(len >> 8);
        pkt[5]  = 8'(len);
        pkt[6]  = nxt;
        pkt[23] = src;
        pkt[39] = dst;
    endtask

    task automatic clear_obs();
        obs_pay.delete();
        obs_err.delete();
        obs_done  = 0;
        obs_valid = 0;
    endtask

    task automatic good_a123(input logic [7:0] dst);
        build(3, dst, 8'h3A, 8'h5C, 3);
        pkt[40] = 8'hA1; pkt[41] = 8'hA2; pkt[42] = 8'hA3;
    endtask

    initial begin
        bit         acc;
        int         kind, len, n, v;
        logic [7:0] d, tmp;

        bus.rx_valid = 0; bus.rx_sop = 0; bus.rx_data = 8'h00; bus.pay_ready = 0;
        model_reset();
        #1;
        chk("ready_in_reset", bus.rx_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compare_all();
        chk("rst_pay_data", bus.pay_data, 8'h00);

        // Good packet.
        clear_obs();
        good_a123(8'h01);
        send_pkt(43);
        idle(3);
        chk("good_n", obs_pay.size(), 3);
        chk("good_b0", obs_pay.size() > 0 ? obs_pay[0] : 0, 9'h0A1);
        chk("good_b1", obs_pay.size() > 1 ? obs_pay[1] : 0, 9'h0A2);
        chk("good_b2", obs_pay.size() > 2 ? obs_pay[2] : 0, 9'h1A3);
        chk("good_done", obs_done, 1);
        chk("good_next", bus.hdr_next, 8'h3A);
        chk("good_src", bus.hdr_src, 8'h5C);

        // Backpressure after A1.
        clear_obs();
        good_a123(8'h01);
        send_pkt(41);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'hA2, 1'b0, acc);
            chk("bp_ready_low", last_ready, 0);
        end
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        idle(3);
        chk("bp_n", obs_pay.size(), 3);
        chk("bp_b0", obs_pay.size() > 0 ? obs_pay[0] : 0, 9'h0A1);
        chk("bp_b2", obs_pay.size() > 2 ? obs_pay[2] : 0, 9'h1A3);

        // Bad version, then a good packet.
        clear_obs();
        good_a123(8'h01);
        pkt[0] = 8'h45;
        send_pkt(43);
        chk("ver_code", obs_err.size() == 1 ? obs_err[0] : -1, 0);
        clear_obs();
        good_a123(8'h01);
        send_pkt(43);
        idle(2);
        chk("ver_recover", obs_done, 1);

        // Length 0 and 17.
        clear_obs();
        build(0, 8'h01, 8'h11, 8'h22, 3);
        send_pkt(43);
        chk("len0_code", obs_err.size() == 1 ? obs_err[0] : -1, 1);
        clear_obs();
        build(17, 8'h01, 8'h11, 8'h22, 17);
        send_pkt(57);
        chk("len17_code", obs_err.size() == 1 ? obs_err[0] : -1, 1);

        // Destination mismatch and broadcast.
        clear_obs();
        good_a123(8'h02);
        send_pkt(43);
        idle(2);
        chk("dst2_code", obs_err.size() == 1 ? obs_err[0] : -1, 3);
        chk("dst2_no_valid", obs_valid, 0);
        clear_obs();
        good_a123(8'hFF);
        send_pkt(43);
        idle(2);
        chk("dstff_done", obs_done, 1);

        // Sop at header byte 20, then the new packet parses.
        clear_obs();
        good_a123(8'h01);
        send_pkt(20);
        good_a123(8'h01);
        send_pkt(43);
        idle(2);
        chk("abort_code", obs_err.size() == 1 ? obs_err[0] : -1, 2);
        chk("abort_next_done", obs_done, 1);

        // Timeout after byte 10.
        clear_obs();
        good_a123(8'h01);
        send_pkt(11);
        idle(256);
        chk("tmo_code", obs_err.size() == 1 ? obs_err[0] : -1, 2);

        // Reset during PAY.
        good_a123(8'h01);
        send_pkt(42);
        bus.rx_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_pv", bus.pay_valid, 0);
        chk("rst_pd", bus.pay_data, 8'h00);
        chk("rst_pl", bus.pay_last, 0);
        chk("rst_err", bus.pkt_err, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_next", bus.hdr_next, 8'h00);
        chk("rst_rdy", bus.rx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_obs();
        idle(3);
        chk("rst_no_err", obs_err.size(), 0);

        // Randomized traffic.
        gaps = 1'b1;
        pr_force = -1;
        for (int p = 0; p < 80; p++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, MaxPay);
            build(len, $urandom_range(0, 1) ? NodeAddr : 8'hFF, 8'($urandom), 8'($urandom),
                  MaxPay);
            n = 40 + len;
            case (kind)
                0: begin
                    v = $urandom_range(0, 14);
                    if (v >= 6) v++;
                    tmp = pkt[0];
                    pkt[0] = {4'(v), tmp[3:0]};
                    n = $urandom_range(1, 20);
                end
                1: begin
                    len = $urandom_range(0, 1) ? 0 : $urandom_range(MaxPay + 1, 600);
                    pkt[4] = 8'(len >> 8);
                    pkt[5] = 8'(len);
                    n = 40 + $urandom_range(0, 4);
                end
                2: begin
                    do d = 8'($urandom); while (d == NodeAddr || d == 8'hFF);
                    pkt[39] = d;
                    n = 40 + $urandom_range(0, 3);
                end
                3, 4: n = $urandom_range(1, 40 + len - 1);
                default: ;
            endcase
            send_pkt(n);
            if (kind == 4 && $urandom_range(0, 2) == 0) idle(Tmo + 1);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
        end
        pr_force = 1;
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
